// File: rtl/lfsr_arb_ctrl.sv
// Round-robin arbiter for two requesters that share one 8-bit XNOR LFSR.
// Each grant runs the LFSR a requested number of steps and returns its value with a done pulse.
module lfsr_arb_ctrl #(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [7:0]        seed,
    input  logic [1:0]        req,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [7:0]        data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              ptr_q, ptr_d;
    logic              win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= 8'h00;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // ptr_q holds the last granted requester; a tie goes to the other one.
    assign win = (req == 2'b11) ? ~ptr_q : req[1];

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    // All-ones is the lock-up state of an XNOR LFSR.
                    lfsr_d = (seed == 8'hFF) ? 8'h00 : seed;
                end else if (req != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cnt_d   = win ? steps1 : steps0;
                    state_d = RUN;
                end
            end
            RUN: begin
                lfsr_d = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[4])};
                // A latched count of zero wraps and yields 2^STEP_W shifts.
                cnt_d  = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt      = gnt_q;
    assign done     = (state_q == DONE) ? gnt_q : 2'b00;
    assign busy     = (state_q != IDLE);
    assign data_out = lfsr_q;

endmodule

// File: tb/tb_lfsr_arb_ctrl.sv
// Scoreboard bench for lfsr_arb_ctrl: the driver queues expected done/data pairs,
// the monitor pops and compares them on every done pulse.
module tb_lfsr_arb_ctrl;

    logic       clk;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed;
    logic [1:0] req;
    logic [3:0] steps0;
    logic [3:0] steps1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] data_out;
    logic       busy;

    int n_tests;
    int n_fail;
    int gnt_bad;

    typedef struct packed {
        logic [1:0] dn;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    lfsr_arb_ctrl #(.STEP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .steps0    (steps0),
        .steps1    (steps1),
        .gnt       (gnt),
        .done      (done),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (gnt == 2'b11) gnt_bad++;
        if (rst_n && done != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {22'd0, done, data_out}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_vec", {30'd0, done}, {30'd0, e.dn});
                chk("data_out", {24'd0, data_out}, {24'd0, e.data});
            end
        end
    end

    // Waits (bounded) for done[idx]; returns the number of busy cycles seen.
    task automatic wait_done(input int idx, output int busy_cnt);
        int k;
        busy_cnt = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done[idx]) break;
        end
        if (k == 100) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    int bc;

    initial begin
        n_tests = 0; n_fail = 0; gnt_bad = 0;
        seed_load = 1'b0; seed = 8'h00; req = 2'b00;
        steps0 = 4'd0; steps1 = 4'd0;
        rst_n = 1'b0;
        idle_cycles(2);
        chk("rst_gnt",  {30'd0, gnt}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        idle_cycles(1);

        // Single request, five shifts from the reset LFSR.
        steps0 = 4'd5;
        exp_q.push_back('{dn: 2'b01, data: 8'h1F});
        req = 2'b01;
        @(negedge clk);
        chk("gnt_single", {30'd0, gnt}, 32'd1);
        wait_done(0, bc);
        req = 2'b00;
        chk("busy_cycles_5", bc + 1, 32'd6);
        idle_cycles(2);

        // Both requesting from reset: requester 0 first, then 1.
        do_reset();
        steps0 = 4'd1; steps1 = 4'd1;
        exp_q.push_back('{dn: 2'b01, data: 8'h01});
        exp_q.push_back('{dn: 2'b10, data: 8'h03});
        req = 2'b11;
        wait_done(0, bc);
        req = 2'b10;
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("gnt_second", {30'd0, gnt}, 32'd2);
        wait_done(1, bc);
        req = 2'b00;
        idle_cycles(2);

        // Seed 0xFF becomes 0x00, so one shift gives 0x01.
        seed = 8'hFF; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        exp_q.push_back('{dn: 2'b01, data: 8'h01});
        steps0 = 4'd1; req = 2'b01;
        wait_done(0, bc);
        req = 2'b00;
        idle_cycles(1);

        // Seed 0x80 shifted once: XNOR(1,0)=0 gives 0x00.
        seed = 8'h80; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        exp_q.push_back('{dn: 2'b01, data: 8'h00});
        req = 2'b01;
        wait_done(0, bc);
        req = 2'b00;
        idle_cycles(1);

        // Seed load together with a request: the load wins the first cycle.
        seed = 8'h80; seed_load = 1'b1; steps1 = 4'd1; req = 2'b10;
        exp_q.push_back('{dn: 2'b10, data: 8'h00});
        @(negedge clk);
        chk("seed_wins_gnt",  {30'd0, gnt}, 32'd0);
        chk("seed_wins_busy", {31'd0, busy}, 32'd0);
        seed_load = 1'b0;
        @(negedge clk);
        chk("gnt_after_seed", {30'd0, gnt}, 32'd2);
        wait_done(1, bc);
        req = 2'b00;
        idle_cycles(1);

        // Step count 0 means 16 shifts; req dropped mid-RUN must not abort.
        steps1 = 4'd0; req = 2'b10;
        exp_q.push_back('{dn: 2'b10, data: 8'hC1});
        @(negedge clk);
        chk("gnt_wrap", {30'd0, gnt}, 32'd2);
        req = 2'b00;
        wait_done(1, bc);
        chk("busy_cycles_16", bc + 1, 32'd17);
        idle_cycles(2);

        // Reset mid-RUN aborts with no done pulse and clears the LFSR.
        steps0 = 4'd5; req = 2'b01;
        idle_cycles(3);
        chk("run_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt",  {30'd0, gnt}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {30'd0, done}, 32'd0);
        chk("abort_data", {24'd0, data_out}, 32'd0);
        req = 2'b00;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(10);
        chk("no_done_after_abort", exp_q.size(), 32'd0);

        // After reset the pointer favours requester 0 again and the LFSR restarts at 0x00.
        steps0 = 4'd1; steps1 = 4'd1;
        exp_q.push_back('{dn: 2'b01, data: 8'h01});
        req = 2'b11;
        wait_done(0, bc);
        req = 2'b00;
        idle_cycles(3);

        chk("queue_drained", exp_q.size(), 32'd0);
        chk("gnt_never_11", gnt_bad, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
